// File: rtl/perm_writeback_aligner_pkg.sv
// Shared configuration for the permute write-back slice: lane count, select width,
// default map FIFO depth and the count-width helper.
`ifndef P
`define P 2
`endif
`ifndef MAP
`define MAP 3
`endif

package perm_writeback_aligner_pkg;

    localparam int LANES     = 2 * `P;
    localparam int SEL_W     = `MAP;
    localparam int DEPTH_DEF = 8;

    function automatic int count_width(input int depth);
        return $clog2(depth) + 1;
    endfunction

    localparam int COUNT_W = count_width(DEPTH_DEF);

    // Map faults seen on the popped map; duplicates are only reported when checking is built in.
    typedef struct packed {
        logic oob;
        logic dup;
    } map_fault_t;

endpackage

// File: rtl/perm_writeback_aligner_map_fifo.sv
// Power-of-two select-map FIFO; the caller gates push/pop on full/empty derived from count.
module perm_map_fifo
    import perm_writeback_aligner_pkg::*;
#(
    parameter int WIDTH = LANES * SEL_W,
    parameter int DEPTH = DEPTH_DEF
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   clear,
    input  logic                   push,
    input  logic                   pop,
    input  logic [WIDTH-1:0]       din,
    output logic [WIDTH-1:0]       dout,
    output logic [$clog2(DEPTH):0] count
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = count_width(DEPTH);

    logic [WIDTH-1:0] mem_r [DEPTH];
    logic [AW-1:0]    wr_ptr_r;
    logic [AW-1:0]    rd_ptr_r;
    logic [CW-1:0]    count_r;

    // Storage array; contents need no reset because count gates every read.
    always_ff @(posedge clk) begin
        if (push && !clear) begin
            mem_r[wr_ptr_r] <= din;
        end
    end

    // Pointers wrap naturally modulo DEPTH; count tracks occupancy.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_r <= {AW{1'b0}};
            rd_ptr_r <= {AW{1'b0}};
            count_r  <= {CW{1'b0}};
        end else if (clear) begin
            wr_ptr_r <= {AW{1'b0}};
            rd_ptr_r <= {AW{1'b0}};
            count_r  <= {CW{1'b0}};
        end else begin
            if (push) begin
                wr_ptr_r <= wr_ptr_r + AW'(1);
            end
            if (pop) begin
                rd_ptr_r <= rd_ptr_r + AW'(1);
            end
            case ({push, pop})
                2'b10:   count_r <= count_r + CW'(1);
                2'b01:   count_r <= count_r - CW'(1);
                default: count_r <= count_r;
            endcase
        end
    end

    assign dout  = mem_r[rd_ptr_r];
    assign count = count_r;

endmodule

// File: rtl/perm_writeback_aligner.sv
// Write-back aligner: pairs each PE result beat with its queued lane-select map and scatters
// lanes back to their source banks. PERM_WB_DUPCHECK_EN adds bank-collision reporting on err.
module perm_writeback_aligner
    import perm_writeback_aligner_pkg::*;
#(
    parameter int N     = LANES,
    parameter int W     = 32,
    parameter int SELW  = SEL_W,
    parameter int DEPTH = DEPTH_DEF
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   clear,
    input  logic                   map_valid,
    output logic                   map_ready,
    input  logic [N*SELW-1:0]      map_sel,
    input  logic                   res_valid,
    output logic                   res_ready,
    input  logic [N*W-1:0]         res_data,
    output logic                   wb_valid,
    input  logic                   wb_ready,
    output logic [N*W-1:0]         wb_data,
    output logic [N-1:0]           wb_mask,
    output logic [$clog2(DEPTH):0] map_count,
    output logic                   err
);

    localparam int CW = count_width(DEPTH);

    logic              push_s;
    logic              pop_s;
    logic [N*SELW-1:0] head_sel_s;
    logic [N*W-1:0]    perm_data_s;
    logic [N-1:0]      perm_mask_s;
    map_fault_t        fault_s;

    assign map_ready = (map_count != CW'(DEPTH));
    assign res_ready = (map_count != {CW{1'b0}}) && (!wb_valid || wb_ready);
    assign push_s    = map_valid && map_ready && !clear;
    assign pop_s     = res_valid && res_ready && !clear;

    perm_map_fifo #(
        .WIDTH (N * SELW),
        .DEPTH (DEPTH)
    ) u_map_fifo (
        .clk   (clk),
        .rst   (rst),
        .clear (clear),
        .push  (push_s),
        .pop   (pop_s),
        .din   (map_sel),
        .dout  (head_sel_s),
        .count (map_count)
    );

    // Inverse permutation of the head map: ascending lane scan lets the highest lane win a bank.
    always_comb begin
        perm_data_s = {(N*W){1'b0}};
        perm_mask_s = {N{1'b0}};
        fault_s     = '{oob: 1'b0, dup: 1'b0};
        for (int k = 0; k < N; k++) begin
            for (int m = 0; m < N; m++) begin
                perm_data_s[m*W +: W] = (int'(head_sel_s[k*SELW +: SELW]) == m) ?
                                        res_data[k*W +: W] : perm_data_s[m*W +: W];
                perm_mask_s[m]        = perm_mask_s[m] |
                                        (int'(head_sel_s[k*SELW +: SELW]) == m);
            end
            fault_s.oob = fault_s.oob | (int'(head_sel_s[k*SELW +: SELW]) >= N);
        end
`ifdef PERM_WB_DUPCHECK_EN
        for (int j = 0; j < N; j++) begin
            for (int k = j + 1; k < N; k++) begin
                fault_s.dup = fault_s.dup |
                              ((int'(head_sel_s[j*SELW +: SELW]) < N) &&
                               (head_sel_s[j*SELW +: SELW] == head_sel_s[k*SELW +: SELW]));
            end
        end
`endif
    end

    // Output register: holds a beat until wb_ready, reloads in the same cycle for full rate.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wb_valid <= 1'b0;
            wb_data  <= {(N*W){1'b0}};
            wb_mask  <= {N{1'b0}};
            err      <= 1'b0;
        end else if (clear) begin
            wb_valid <= 1'b0;
            wb_data  <= {(N*W){1'b0}};
            wb_mask  <= {N{1'b0}};
            err      <= 1'b0;
        end else if (pop_s) begin
            wb_valid <= 1'b1;
            wb_data  <= perm_data_s;
            wb_mask  <= perm_mask_s;
            err      <= err | fault_s.oob | fault_s.dup;
        end else if (wb_ready) begin
            wb_valid <= 1'b0;
        end else begin
            wb_valid <= wb_valid;
        end
    end

endmodule

// File: tb/tb_perm_writeback_aligner.sv
// Scoreboard bench for perm_writeback_aligner at N=4, W=8, SELW=3, DEPTH=4.
module tb_perm_writeback_aligner;

    localparam int N = 4, W = 8, SELW = 3, DEPTH = 4;

    logic              clk = 1'b0;
    logic              rst, clear, map_valid, res_valid, wb_ready;
    logic [N*SELW-1:0] map_sel;
    logic [N*W-1:0]    res_data;
    logic              map_ready, res_ready, wb_valid, err;
    logic [N*W-1:0]    wb_data;
    logic [N-1:0]      wb_mask;
    logic [2:0]        map_count;

    typedef struct packed {
        logic [N*W-1:0] data;
        logic [N-1:0]   mask;
        logic           err;
    } exp_t;

    logic [N*SELW-1:0] map_q [$];
    exp_t              exp_q [$];
    logic              err_model;
    int                n_cmp = 0, n_fail = 0;

    perm_writeback_aligner #(.N(N), .W(W), .SELW(SELW), .DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst), .clear(clear),
        .map_valid(map_valid), .map_ready(map_ready), .map_sel(map_sel),
        .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data),
        .wb_valid(wb_valid), .wb_ready(wb_ready), .wb_data(wb_data), .wb_mask(wb_mask),
        .map_count(map_count), .err(err)
    );

    always #5 clk = ~clk;

    function automatic logic [N*SELW-1:0] mk_map(input int a, input int b, input int c, input int d);
        return {SELW'(d), SELW'(c), SELW'(b), SELW'(a)};
    endfunction

    // Reference: each bank searches lanes from the top down for the first lane selecting it.
    function automatic exp_t model(input logic [N*SELW-1:0] sel, input logic [N*W-1:0] res,
                                   input logic err_in);
        exp_t e;
        bit   found;
        e.data = '0; e.mask = '0; e.err = err_in;
        for (int m = 0; m < N; m++) begin
            found = 1'b0;
            for (int k = N - 1; k >= 0; k--) begin
                if (!found && int'(sel[k*SELW +: SELW]) == m) begin
                    e.data[m*W +: W] = res[k*W +: W];
                    e.mask[m] = 1'b1;
                    found = 1'b1;
                end
            end
        end
        for (int k = 0; k < N; k++) if (int'(sel[k*SELW +: SELW]) >= N) e.err = 1'b1;
`ifdef PERM_WB_DUPCHECK_EN
        for (int j = 0; j < N; j++)
            for (int k = j + 1; k < N; k++)
                if (int'(sel[j*SELW +: SELW]) < N && sel[j*SELW +: SELW] == sel[k*SELW +: SELW])
                    e.err = 1'b1;
`endif
        return e;
    endfunction

    task automatic step;
        @(posedge clk);
        #2;
    endtask

    task automatic push_map(input logic [N*SELW-1:0] s);
        map_valid = 1'b1;
        map_sel   = s;
        n_cmp++;
        if (map_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL push_ready got %b want 1", map_ready);
        end
        step;
        map_valid = 1'b0;
        map_q.push_back(s);
    endtask

    task automatic accept_res(input logic [N*W-1:0] d);
        exp_t e;
        int   n = 0;
        res_valid = 1'b1;
        res_data  = d;
        #1;
        while (res_ready !== 1'b1 && n < 20) begin
            step;
            n++;
        end
        if (n == 20 || map_q.size() == 0) begin
            n_cmp++; n_fail++;
            $display("FAIL res_accept_timeout got res_ready=%b want 1", res_ready);
            res_valid = 1'b0;
        end else begin
            step;
            res_valid = 1'b0;
            e = model(map_q.pop_front(), d, err_model);
            err_model = e.err;
            exp_q.push_back(e);
        end
    endtask

    task automatic flush_model;
        map_q.delete();
        exp_q.delete();
        err_model = 1'b0;
    endtask

    task automatic test_reset;
        rst = 1'b1; clear = 1'b0; map_valid = 1'b0; res_valid = 1'b0; wb_ready = 1'b1;
        map_sel = '0; res_data = '0;
        flush_model();
        step; step;
        n_cmp += 7;
        if (map_count !== 3'd0) begin n_fail++; $display("FAIL rst_count got %0d want 0", map_count); end
        if (wb_valid !== 1'b0)  begin n_fail++; $display("FAIL rst_valid got %b want 0", wb_valid); end
        if (wb_data !== 32'h0)  begin n_fail++; $display("FAIL rst_data got %h want 0", wb_data); end
        if (wb_mask !== 4'h0)   begin n_fail++; $display("FAIL rst_mask got %b want 0", wb_mask); end
        if (err !== 1'b0)       begin n_fail++; $display("FAIL rst_err got %b want 0", err); end
        if (map_ready !== 1'b1) begin n_fail++; $display("FAIL rst_map_ready got %b want 1", map_ready); end
        if (res_ready !== 1'b0) begin n_fail++; $display("FAIL rst_res_ready got %b want 0", res_ready); end
        rst = 1'b0;
        step;
    endtask

    task automatic test_basic;
        exp_t e;
        push_map(mk_map(2, 0, 3, 1));
        accept_res(32'hA3A2A1A0);
        e = exp_q.pop_front();
        n_cmp += 5;
        if (wb_valid !== 1'b1)       begin n_fail++; $display("FAIL basic_valid got %b want 1", wb_valid); end
        if (wb_data !== e.data)      begin n_fail++; $display("FAIL basic_data got %h want %h", wb_data, e.data); end
        if (wb_data !== 32'hA2A0A3A1) begin n_fail++; $display("FAIL basic_literal got %h want a2a0a3a1", wb_data); end
        if (wb_mask !== 4'b1111)     begin n_fail++; $display("FAIL basic_mask got %b want 1111", wb_mask); end
        if (err !== 1'b0)            begin n_fail++; $display("FAIL basic_err got %b want 0", err); end
        step;
        n_cmp++;
        if (wb_valid !== 1'b0) begin n_fail++; $display("FAIL basic_drain got %b want 0", wb_valid); end
    endtask

    task automatic test_full;
        exp_t e;
        push_map(mk_map(0, 1, 2, 3));
        push_map(mk_map(3, 2, 1, 0));
        push_map(mk_map(1, 2, 3, 0));
        push_map(mk_map(2, 3, 0, 1));
        n_cmp += 2;
        if (map_count !== 3'd4) begin n_fail++; $display("FAIL full_count got %0d want 4", map_count); end
        if (map_ready !== 1'b0) begin n_fail++; $display("FAIL full_ready got %b want 0", map_ready); end
        map_valid = 1'b1;
        map_sel   = mk_map(1, 1, 1, 1);
        step;
        n_cmp++;
        if (map_count !== 3'd4) begin n_fail++; $display("FAIL full_hold got %0d want 4", map_count); end
        accept_res(32'h13121110);
        map_valid = 1'b0;
        n_cmp++;
        if (map_count !== 3'd3) begin n_fail++; $display("FAIL full_pushpop got %0d want 3", map_count); end
        for (int i = 0; i < 4; i++) begin
            if (i > 0) accept_res(32'h23222120 + 32'(i * 32'h01010101));
            e = exp_q.pop_front();
            n_cmp += 3;
            if (wb_valid !== 1'b1)  begin n_fail++; $display("FAIL full_valid%0d got %b want 1", i, wb_valid); end
            if (wb_data !== e.data) begin n_fail++; $display("FAIL full_data%0d got %h want %h", i, wb_data, e.data); end
            if (wb_mask !== e.mask) begin n_fail++; $display("FAIL full_mask%0d got %b want %b", i, wb_mask, e.mask); end
        end
        step;
        n_cmp += 2;
        if (wb_valid !== 1'b0)  begin n_fail++; $display("FAIL full_end_valid got %b want 0", wb_valid); end
        if (map_count !== 3'd0) begin n_fail++; $display("FAIL full_end_count got %0d want 0", map_count); end
    endtask

    task automatic test_stall;
        exp_t e;
        res_valid = 1'b1;
        res_data  = 32'h37363534;
        for (int i = 0; i < 3; i++) begin
            #1;
            n_cmp += 2;
            if (res_ready !== 1'b0) begin n_fail++; $display("FAIL stall_ready%0d got %b want 0", i, res_ready); end
            if (wb_valid !== 1'b0)  begin n_fail++; $display("FAIL stall_valid%0d got %b want 0", i, wb_valid); end
            step;
        end
        push_map(mk_map(0, 2, 1, 3));
        accept_res(32'h37363534);
        e = exp_q.pop_front();
        n_cmp += 2;
        if (wb_valid !== 1'b1)  begin n_fail++; $display("FAIL stall_done got %b want 1", wb_valid); end
        if (wb_data !== e.data) begin n_fail++; $display("FAIL stall_data got %h want %h", wb_data, e.data); end
        step;
    endtask

    task automatic test_oob;
        exp_t e;
        push_map(mk_map(5, 1, 2, 3));
        accept_res(32'hB3B2B1B0);
        e = exp_q.pop_front();
        n_cmp += 5;
        if (wb_mask !== 4'b1110)   begin n_fail++; $display("FAIL oob_mask got %b want 1110", wb_mask); end
        if (wb_mask !== e.mask)    begin n_fail++; $display("FAIL oob_model_mask got %b want %b", wb_mask, e.mask); end
        if (wb_data[7:0] !== 8'h0) begin n_fail++; $display("FAIL oob_bank0 got %h want 00", wb_data[7:0]); end
        if (wb_data !== e.data)    begin n_fail++; $display("FAIL oob_data got %h want %h", wb_data, e.data); end
        if (err !== 1'b1)          begin n_fail++; $display("FAIL oob_err got %b want 1", err); end
        step;
        push_map(mk_map(0, 1, 2, 3));
        n_cmp++;
        if (err !== 1'b1) begin n_fail++; $display("FAIL oob_sticky got %b want 1", err); end
        clear = 1'b1;
        step;
        clear = 1'b0;
        flush_model();
        n_cmp += 2;
        if (err !== 1'b0)       begin n_fail++; $display("FAIL clear_err got %b want 0", err); end
        if (map_count !== 3'd0) begin n_fail++; $display("FAIL clear_count got %0d want 0", map_count); end
    endtask

    task automatic test_back_to_back;
        exp_t e;
        wb_ready = 1'b0;
        push_map(mk_map(3, 0, 1, 2));
        push_map(mk_map(1, 0, 3, 2));
        accept_res(32'h44434241);
        res_valid = 1'b1;
        res_data  = 32'h54535251;
        for (int i = 0; i < 3; i++) begin
            #1;
            n_cmp += 3;
            if (res_ready !== 1'b0)        begin n_fail++; $display("FAIL bp_ready%0d got %b want 0", i, res_ready); end
            if (wb_valid !== 1'b1)         begin n_fail++; $display("FAIL bp_valid%0d got %b want 1", i, wb_valid); end
            if (wb_data !== exp_q[0].data) begin n_fail++; $display("FAIL bp_hold%0d got %h want %h", i, wb_data, exp_q[0].data); end
            step;
        end
        wb_ready  = 1'b1;
        map_valid = 1'b1;
        map_sel   = mk_map(2, 1, 0, 3);
        accept_res(32'h54535251);
        map_valid = 1'b0;
        map_q.push_back(mk_map(2, 1, 0, 3));
        e = exp_q.pop_front();
        e = exp_q.pop_front();
        n_cmp += 3;
        if (map_count !== 3'd1) begin n_fail++; $display("FAIL b2b_count got %0d want 1", map_count); end
        if (wb_valid !== 1'b1)  begin n_fail++; $display("FAIL b2b_valid got %b want 1", wb_valid); end
        if (wb_data !== e.data) begin n_fail++; $display("FAIL b2b_data got %h want %h", wb_data, e.data); end
        accept_res(32'h64636261);
        e = exp_q.pop_front();
        n_cmp += 2;
        if (wb_data !== e.data) begin n_fail++; $display("FAIL b2b_data3 got %h want %h", wb_data, e.data); end
        if (wb_mask !== e.mask) begin n_fail++; $display("FAIL b2b_mask3 got %b want %b", wb_mask, e.mask); end
        step;
    endtask

    task automatic test_async_reset;
        wb_ready = 1'b0;
        push_map(mk_map(6, 1, 2, 3));
        push_map(mk_map(0, 1, 2, 3));
        push_map(mk_map(1, 2, 3, 0));
        push_map(mk_map(2, 3, 0, 1));
        accept_res(32'h74737271);
        n_cmp += 3;
        if (map_count !== 3'd3) begin n_fail++; $display("FAIL ar_pre_count got %0d want 3", map_count); end
        if (wb_valid !== 1'b1)  begin n_fail++; $display("FAIL ar_pre_valid got %b want 1", wb_valid); end
        if (err !== 1'b1)       begin n_fail++; $display("FAIL ar_pre_err got %b want 1", err); end
        #1 rst = 1'b1;
        #1;
        n_cmp += 5;
        if (map_count !== 3'd0) begin n_fail++; $display("FAIL ar_count got %0d want 0", map_count); end
        if (wb_valid !== 1'b0)  begin n_fail++; $display("FAIL ar_valid got %b want 0", wb_valid); end
        if (err !== 1'b0)       begin n_fail++; $display("FAIL ar_err got %b want 0", err); end
        if (wb_data !== 32'h0)  begin n_fail++; $display("FAIL ar_data got %h want 0", wb_data); end
        if (wb_mask !== 4'h0)   begin n_fail++; $display("FAIL ar_mask got %b want 0", wb_mask); end
        flush_model();
        step;
        rst = 1'b0;
        wb_ready = 1'b1;
        step;
    endtask

    task automatic test_dup;
        exp_t e;
        push_map(mk_map(1, 1, 2, 3));
        accept_res(32'hC3C2C1C0);
        e = exp_q.pop_front();
        n_cmp += 4;
        if (wb_data[15:8] !== 8'hC1) begin n_fail++; $display("FAIL dup_bank1 got %h want c1", wb_data[15:8]); end
        if (wb_data !== e.data)      begin n_fail++; $display("FAIL dup_data got %h want %h", wb_data, e.data); end
        if (wb_mask !== 4'b1110)     begin n_fail++; $display("FAIL dup_mask got %b want 1110", wb_mask); end
        if (err !== e.err)           begin n_fail++; $display("FAIL dup_err got %b want %b", err, e.err); end
        step;
        clear = 1'b1;
        step;
        clear = 1'b0;
        flush_model();
    endtask

    initial begin
        test_reset();
        test_basic();
        test_full();
        test_stall();
        test_oob();
        test_back_to_back();
        test_async_reset();
        test_dup();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got timeout want completion");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/perm_writeback_aligner.md
Name: perm_writeback_aligner

Overview:
- Write-back end of the multi-lane read/permute path.
- Accepts the per-beat lane-select map used to gather operands from the banks and queues it until the matching PE result beat returns.
- Applies the inverse permutation, out[sel[k]] = in[k], so each result lane lands on the bank it was read from.
- Registered, handshaked output with per-bank write mask, feeding the bank write ports.

Parameters:
- N, 2*`P: lane/bank count.
- W, 32: data width per lane.
- SELW, `MAP: select field width per lane.
- DEPTH, 8: map FIFO depth; power of two, ≥ PE pipeline latency in beats.

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous active-high reset.
- clear  in  1  synchronous flush of FIFO, output register and error flag.
- map_valid  in  1  select map presented.
- map_ready  out  1  FIFO can accept a map.
- map_sel  in  N*SELW  lane k field = bank index read into lane k.
- res_valid  in  1  PE result beat presented.
- res_ready  out  1  result beat accepted.
- res_data  in  N*W  PE results, lane order.
- wb_valid  out  1  write-back beat valid.
- wb_ready  in  1  bank side accepts the beat.
- wb_data  out  N*W  bank-ordered data.
- wb_mask  out  N  bank m written this beat.
- map_count  out  $clog2(DEPTH)+1  maps queued.
- err  out  1  sticky map-fault flag.

Behaviour:
- Reset is asynchronous, active-high. While rst=1: FIFO pointers and map_count 0, wb_valid 0, wb_data 0, wb_mask 0, err 0.
- Map push: push when map_valid && map_ready. map_ready = (map_count != DEPTH). No push-through when full, even if a pop happens in the same cycle.
- Result accept: res_ready = (map_count != 0) && (!wb_valid || wb_ready). A result with no queued map is stalled, never dropped.
- On res_valid && res_ready: pop the head map and register the result, 1-cycle latency, into wb_data/wb_mask.
  - For each bank m: wb_data[m] = res_data[k], where k is the highest lane with sel[k]==m; wb_mask[m]=1.
  - Banks with no lane mapping to them: data 0, mask 0.
  - Lanes with sel[k] ≥ N are discarded.
- Output register holds wb_valid=1 and stable data/mask until wb_ready. It clears on wb_ready unless a new beat loads in the same cycle, which gives full throughput of one beat per cycle.
- Simultaneous push and pop: map_count unchanged; the pushed map is never the popped map.
- Pointers are DEPTH-modulo with wrap-around; full/empty are derived from map_count.
- clear: has priority over push and pop in the same cycle. Next state equals reset state; in-flight handshakes that cycle are ignored.
- Reset mid-operation: all queued maps and the pending beat are lost. Upstream must restart from a beat boundary.
- err: set on a popped map containing any sel ≥ N. Cleared only by rst or clear.

Optional Feature:
- Macro PERM_WB_DUPCHECK_EN.
- Defined: err also sets when a popped map has two lanes with equal in-range sel (bank collision), and the affected bank still takes the highest lane.
- Undefined: no duplicate comparator logic; err reflects out-of-range only.

Decomposition:
- Shared include: `P, `MAP, derived N and the count width constant.
- Sub-module perm_map_fifo: synchronous FIFO, width N*SELW, parameter DEPTH, with push/pop/clear/count.
- The inverse-permute and mask logic stays inline in perm_writeback_aligner.

Test Plan (N=4, W=8, SELW=3, DEPTH=4):
- Push map {k0:2,k1:0,k2:3,k3:1}, then result {0xA0,0xA1,0xA2,0xA3} → next cycle wb_data bank0..3 = {0xA1,0xA3,0xA0,0xA2}, wb_mask=4'b1111, err=0.
- Push 4 maps with no results → map_ready=0, map_count=4. Fifth push is held; push+pop in the same cycle when full does not accept the push.
- Assert result with map_count=0 → res_ready=0 and wb_valid stays 0. A map pushed later lets the beat complete in order.
- Map {k0:5,k1:1,k2:2,k3:3} → wb_mask=4'b1110, bank0 data 0, err=1 until clear.
- Hold wb_ready=0 for 3 cycles with 2 maps and results pending → wb_data stable, res_ready=0. wb_ready=1 then drains both beats on consecutive cycles.
- Assert rst with 3 maps queued and wb_valid=1 → map_count=0, wb_valid=0, err=0 immediately (asynchronous). With PERM_WB_DUPCHECK_EN, map {1,1,2,3} → err=1, bank1 gets lane1 data.
